// File: rtl/alu_mdu.sv
// EX-stage execute unit: add/sub/and/or/sltu/slt in one cycle, iterative unsigned multiply and restoring divide.
// Latency: 1 cycle for ALU ops, WIDTH+1 cycles for multu/divu; start accepted only in IDLE.
// Backpressure: busy stays high until after the done pulse; start seen while busy is dropped, not queued.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] aluInA,
    input  logic [WIDTH-1:0] aluInB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;

    logic [WIDTH-1:0] w_alu;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_rem;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    always_comb begin
        w_alu = '0;
        case (aluOp)
            3'b000:  w_alu = aluInA + aluInB;
            3'b001:  w_alu = aluInA - aluInB;
            3'b010:  w_alu = aluInA & aluInB;
            3'b011:  w_alu = aluInA | aluInB;
            3'b100:  w_alu = {{(WIDTH-1){1'b0}}, (aluInA < aluInB)};
            3'b101:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(aluInA) < $signed(aluInB))};
            default: w_alu = '0;
        endcase
    end

    // Shift-add: r_hi accumulates, r_lo holds the multiplier and fills with product low bits.
    assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Restoring divide: r_hi is the partial remainder, r_lo shifts the dividend out and quotient in.
    // The shifted remainder never exceeds WIDTH bits, so bit WIDTH of the difference is a clean borrow.
    assign w_div_rem  = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff = w_div_rem - {1'b0, r_opnd};
    assign w_div_ge   = ~w_div_diff[WIDTH];
    assign w_div_hi   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem[WIDTH-1:0];
    assign w_div_lo   = {r_lo[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_hi   <= '0;
                        case (aluOp)
                            3'b110: begin
                                r_state <= S_MUL;
                                r_opnd  <= aluInA;
                                r_lo    <= aluInB;
                            end
                            3'b111: begin
                                r_state <= S_DIV;
                                r_opnd  <= aluInB;
                                r_lo    <= aluInA;
                            end
                            default: begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_res_lo <= w_alu;
                                r_res_hi <= '0;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_res_lo <= w_mul_lo;
                        r_res_hi <= w_mul_hi;
                    end
                end
                S_DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_res_lo <= w_div_lo;
                        r_res_hi <= w_div_hi;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign resultLo = r_res_lo;
    assign resultHi = r_res_hi;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: 32-bit and 8-bit instances, scoreboard of expected results checked on each done pulse.
module tb_alu_mdu;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, lo32, hi32;
    logic        start8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, lo8, hi8;

    int   cyc;
    int   n_chk;
    int   n_pass;
    exp_t q32[$];
    exp_t q8[$];
    exp_t m_e32, m_e8;
    logic prev_done32, prev_done8;

    alu_mdu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .aluOp(op32), .aluInA(a32), .aluInB(b32),
        .busy(busy32), .done(done32), .resultLo(lo32), .resultHi(hi32)
    );

    alu_mdu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .aluOp(op8), .aluInA(a8), .aluInB(b8),
        .busy(busy8), .done(done8), .resultLo(lo8), .resultHi(hi8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model written from the operation definitions, independent of the iterative hardware.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [63:0] mask, a64, b64, lo, hi, p;
        mask = (64'd1 << w) - 64'd1;
        a64  = {32'd0, a} & mask;
        b64  = {32'd0, b} & mask;
        lo   = '0;
        hi   = '0;
        case (op)
            3'd0: lo = (a64 + b64) & mask;
            3'd1: lo = (a64 - b64) & mask;
            3'd2: lo = a64 & b64;
            3'd3: lo = a64 | b64;
            3'd4: lo = {63'd0, (a64 < b64)};
            3'd5: begin
                if (a64[w-1] != b64[w-1]) lo = {63'd0, a64[w-1]};
                else                      lo = {63'd0, (a64 < b64)};
            end
            3'd6: begin
                p  = a64 * b64;
                lo = p & mask;
                hi = (p >> w) & mask;
            end
            default: begin
                if (b64 == 64'd0) begin
                    lo = mask;
                    hi = a64;
                end else begin
                    lo = a64 / b64;
                    hi = a64 % b64;
                end
            end
        endcase
        return {hi[31:0], lo[31:0]};
    endfunction

    // Called at a negative edge just before the accepting edge; done is expected `lat` cycles later.
    task automatic push_exp(input bit n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m;
        int          lat;
        m     = model(op, a, b, n ? 8 : 32);
        lat   = (op >= 3'd6) ? (n ? 9 : 33) : 1;
        e.lo  = m[31:0];
        e.hi  = m[63:32];
        e.cyc = cyc + lat;
        if (n) q8.push_back(e);
        else   q32.push_back(e);
    endtask

    task automatic issue(input bit n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit seen;
        push_exp(n, op, a, b);
        if (n) begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start8  = 1'b0;
            start32 = 1'b0;
            if (i == 0) begin
                a32 = $urandom; b32 = $urandom;
                a8  = 8'($urandom); b8 = 8'($urandom);
            end
            if (n ? done8 : done32) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done32) begin
            chk("sb32_entry", q32.size() > 0, 1);
            chk("done32_gap", prev_done32, 0);
            if (q32.size() > 0) begin
                m_e32 = q32.pop_front();
                chk("lo32", lo32, m_e32.lo);
                chk("hi32", hi32, m_e32.hi);
                chk("cyc32", cyc, m_e32.cyc);
            end
        end
        if (done8) begin
            chk("sb8_entry", q8.size() > 0, 1);
            chk("done8_gap", prev_done8, 0);
            if (q8.size() > 0) begin
                m_e8 = q8.pop_front();
                chk("lo8", lo8, m_e8.lo);
                chk("hi8", hi8, m_e8.hi);
                chk("cyc8", cyc, m_e8.cyc);
            end
        end
        prev_done32 <= done32;
        prev_done8  <= done8;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_lo", lo32, 0);
        chk("rst_hi", hi32, 0);
        chk("rst_busy8", busy8, 0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start32 = 1'b1; op32 = 3'd0; a32 = 32'd1; b32 = 32'd1;
        @(negedge clk);
        rst = 1'b0; start32 = 1'b0;
        chk("rst_start_busy", busy32, 0);
        @(negedge clk);
        chk("rst_start_busy2", busy32, 0);
        chk("rst_start_lo", lo32, 0);

        issue(0, 3'd0, 32'hFFFFFFFF, 32'd1);
        issue(0, 3'd1, 32'd3, 32'd5);
        issue(0, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00);
        issue(0, 3'd3, 32'hF0F0F0F0, 32'hFF00FF00);
        issue(0, 3'd4, 32'hFFFFFFFF, 32'd1);
        issue(0, 3'd5, 32'hFFFFFFFF, 32'd1);
        issue(0, 3'd5, 32'd5, 32'd5);

        // multu with start pulses during MUL (cycle 5) and DONE (cycle 33), operands scrambled after capture.
        op32 = 3'd6; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
        push_exp(0, 3'd6, a32, b32);
        start32 = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start32 = (c == 5) || (c == 33);
            a32 = $urandom; b32 = $urandom;
            chk("mul_busy", busy32, (c <= 33));
        end
        start32 = 1'b0;
        @(negedge clk);
        chk("mul_after_busy", busy32, 0);

        issue(0, 3'd7, 32'd100, 32'd7);
        issue(0, 3'd7, 32'd9, 32'd0);

        // Abort a divide at cycle 10.
        op32 = 3'd7; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy32, 0);
        chk("abort_done", done32, 0);
        chk("abort_lo", lo32, 0);
        chk("abort_hi", hi32, 0);
        repeat (30) @(negedge clk);
        issue(0, 3'd0, 32'd2, 32'd2);

        issue(1, 3'd6, 32'hFF, 32'hFF);
        issue(1, 3'd7, 32'd100, 32'd7);
        issue(1, 3'd7, 32'd9, 32'd0);
        issue(1, 3'd5, 32'h80, 32'h7F);

        for (int i = 0; i < 30; i++)
            issue(0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        for (int i = 0; i < 60; i++)
            issue(1, 3'($urandom_range(0, 7)), $urandom, $urandom);

        repeat (5) @(negedge clk);
        chk("sb_drain", q32.size() + q8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
